dmem_mmio: RTL and testbench

Data-side memory subsystem for the single-cycle MIPS core. It consumes the core's data-memory request (memread/memwrite/mem_addr/mem_writedata) and returns mem_readdata combinationally in the same cycle. It holds a word-addressed data RAM plus a memory-mapped register page containing a console output FIFO with a valid/ready drain port and an optional cycle timer.

---
 rtl/dmem_mmio.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_mmio.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio - data-side memory subsystem for the single-cycle MIPS core.
//
// Serves the core's data-memory request combinationally: a word-addressed
// RAM at the bottom of the address space plus a small register page at
// 0xFFFF_0000 holding a console output FIFO (valid/ready drain port) and an
// optional free-running cycle timer.
//
// Optional feature macro: DMEM_TIMER_EN
//   defined   -> TIMER_COUNT / TIMER_CMP registers, STATUS[2] and timer_irq live
//   undefined -> timer addresses decode as unmapped, STATUS[2] and timer_irq
//                read 0, no timer flops exist
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset          in   synchronous, active-high
//   memread        in   core read strobe
//   memwrite       in   core write strobe
//   mem_addr       in   32-bit byte address
//   mem_writedata  in   32-bit store data
//   mem_readdata   out  32-bit load data, combinational, 0 when memread low
//   con_data       out  byte at FIFO head (0 when empty)
//   con_valid      out  FIFO non-empty
//   con_ready      in   sink accepts con_data when con_valid && con_ready
//   bus_err        out  sticky flag: unmapped or misaligned access seen
//   timer_irq      out  level, mirrors the timer flag
module dmem_mmio #(
  parameter int DATA_MEM_WORDS = 1024,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_writedata,
  output logic [31:0] mem_readdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        bus_err,
  output logic        timer_irq
);

  localparam int AW = $clog2(DATA_MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0]   ADDR_CON   = 32'hFFFF_0000;
  localparam logic [31:0]   ADDR_STAT  = 32'hFFFF_0004;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  // ---------------------------------------------------------------- decode
  logic access;
  logic aligned;
  logic hit_ram;
  logic hit_con;
  logic hit_stat;
  logic hit_tcnt;
  logic hit_tcmp;
  logic mapped;

  assign access   = memread | memwrite;
  assign aligned  = (mem_addr[1:0] == 2'b00);
  // RAM occupies 0 .. 4*DATA_MEM_WORDS-1: all bits above the word index zero.
  assign hit_ram  = aligned && (mem_addr[31:AW+2] == '0);
  assign hit_con  = (mem_addr == ADDR_CON);
  assign hit_stat = (mem_addr == ADDR_STAT);
  assign mapped   = hit_ram | hit_con | hit_stat | hit_tcnt | hit_tcmp;

  // ------------------------------------------------------------------- RAM
  // Read is asynchronous because the core expects load data in the same cycle.
  logic [31:0]   ram [DATA_MEM_WORDS];
  logic [AW-1:0] ram_idx;

  assign ram_idx = mem_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (memwrite && hit_ram) begin
      ram[ram_idx] <= mem_writedata;
    end
  end

  // ------------------------------------------------------------ console FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic          bus_err_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_req;
  logic          push_ok;

  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && con_ready;
  assign push_req   = memwrite && hit_con;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is
  // still accepted; it lands in the slot being vacated (wr_ptr == rd_ptr).
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
      if (push_req && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (memwrite && hit_stat) begin
        overflow_reg <= 1'b0;
      end
      if (access && !mapped) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= mem_writedata[7:0];
    end
  end

  // STATUS exposes an 8-bit count field; pad or trim the counter to fit.
  logic [7:0] count_byte;
  generate
    if (CW >= 8) begin : g_cnt_trim
      assign count_byte = count_reg[7:0];
    end else begin : g_cnt_pad
      assign count_byte = {{(8-CW){1'b0}}, count_reg};
    end
  endgenerate

  // ----------------------------------------------------------------- timer
  logic        timer_flag;
  logic [31:0] tcnt_val;
  logic [31:0] tcmp_val;

`ifdef DMEM_TIMER_EN
  localparam logic [31:0] ADDR_TCNT = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_TCMP = 32'hFFFF_000C;

  logic [31:0] tcnt_reg;
  logic [31:0] tcmp_reg;
  logic        flag_reg;

  assign hit_tcnt = (mem_addr == ADDR_TCNT);
  assign hit_tcmp = (mem_addr == ADDR_TCMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_reg <= '0;
      tcmp_reg <= 32'hFFFF_FFFF;
      flag_reg <= 1'b0;
    end else begin
      if (memwrite && hit_tcnt) begin
        tcnt_reg <= mem_writedata;
      end else begin
        tcnt_reg <= tcnt_reg + 32'd1;
      end
      // A compare write re-arms the timer and takes priority over a match.
      if (memwrite && hit_tcmp) begin
        tcmp_reg <= mem_writedata;
        flag_reg <= 1'b0;
      end else if (tcnt_reg == tcmp_reg) begin
        flag_reg <= 1'b1;
      end
    end
  end

  assign timer_flag = flag_reg;
  assign tcnt_val   = tcnt_reg;
  assign tcmp_val   = tcmp_reg;
`else
  assign hit_tcnt   = 1'b0;
  assign hit_tcmp   = 1'b0;
  assign timer_flag = 1'b0;
  assign tcnt_val   = '0;
  assign tcmp_val   = '0;
`endif

  // ------------------------------------------------------------- read path
  logic [31:0] status_word;

  assign status_word = {16'h0000, count_byte, 4'h0,
                        overflow_reg, timer_flag, fifo_empty, fifo_full};

  always_comb begin
    mem_readdata = '0;
    if (memread) begin
      if (hit_ram) begin
        mem_readdata = ram[ram_idx];
      end else if (hit_stat) begin
        mem_readdata = status_word;
      end else if (hit_tcnt) begin
        mem_readdata = tcnt_val;
      end else if (hit_tcmp) begin
        mem_readdata = tcmp_val;
      end
    end
  end

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];
  assign bus_err   = bus_err_reg;
  assign timer_irq = timer_flag;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio - self-checking bench for dmem_mmio.
// Directed steps followed by a randomized phase; every cycle the DUT outputs
// are compared with a behavioural model (associative-array RAM, byte queue
// FIFO, integer timer). Timer checks follow DMEM_TIMER_EN like the design.
module tb_dmem_mmio;

  localparam int WORDS = 1024;
  localparam int DEPTH = 8;

  localparam logic [31:0] A_CON  = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_TCNT = 32'hFFFF_0008;
  localparam logic [31:0] A_TCMP = 32'hFFFF_000C;

  localparam int K_RAM  = 0;
  localparam int K_CON  = 1;
  localparam int K_STAT = 2;
  localparam int K_TCNT = 3;
  localparam int K_TCMP = 4;
  localparam int K_BAD  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        bus_err;
  logic        timer_irq;

  dmem_mmio #(
    .DATA_MEM_WORDS(WORDS),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memread      (memread),
    .memwrite     (memwrite),
    .mem_addr     (mem_addr),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .con_data     (con_data),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .bus_err      (bus_err),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // behavioural model
  logic [31:0] m_ram [int unsigned];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  bit          m_berr;
  bit          m_flag;
  bit          m_ok = 1'b0;
  logic [31:0] m_tcnt;
  logic [31:0] m_tcmp;

  // DUT outputs captured mid-cycle by the most recent cycle() call
  logic [31:0] obs_rdata;
  logic [7:0]  obs_con_data;
  logic        obs_con_valid;
  logic        obs_bus_err;
  logic        obs_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int classify(input logic [31:0] a);
    if (a[1:0] != 2'b00) return K_BAD;
    if (a < 32'(4 * WORDS)) return K_RAM;
    if (a == A_CON) return K_CON;
    if (a == A_STAT) return K_STAT;
`ifdef DMEM_TIMER_EN
    if (a == A_TCNT) return K_TCNT;
    if (a == A_TCMP) return K_TCMP;
`endif
    return K_BAD;
  endfunction

  function automatic logic [31:0] status_model();
    int n;
    n = m_q.size();
    return 32'(n * 256 + (m_ovf ? 8 : 0) + (m_flag ? 4 : 0)
               + (n == 0 ? 2 : 0) + (n == DEPTH ? 1 : 0));
  endfunction

  // One bus cycle: drive at the falling edge, compare combinational outputs
  // against the model, then advance the model at the rising edge.
  task automatic cycle(input bit rst, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit rdy);
    int          kind;
    int unsigned idx;
    bit          pop;
    bit          rd_known;
    logic [31:0] exp_rd;
    @(negedge clk);
    reset = rst; memread = rd; memwrite = wr;
    mem_addr = addr; mem_writedata = wdata; con_ready = rdy;
    #1;
    obs_rdata = mem_readdata; obs_con_data = con_data; obs_con_valid = con_valid;
    obs_bus_err = bus_err; obs_irq = timer_irq;
    kind = classify(addr);
    idx  = addr >> 2;
    if (m_ok) begin
      rd_known = 1'b1;
      exp_rd   = 32'h0;
      if (rd) begin
        case (kind)
          K_RAM:   if (m_ram.exists(idx)) exp_rd = m_ram[idx]; else rd_known = 1'b0;
          K_STAT:  exp_rd = status_model();
          K_TCNT:  exp_rd = m_tcnt;
          K_TCMP:  exp_rd = m_tcmp;
          default: exp_rd = 32'h0;
        endcase
      end
      if (rd_known) check("rdata", mem_readdata, exp_rd);
      check("con_valid", 32'(con_valid), 32'(m_q.size() != 0));
      check("con_data", 32'(con_data), 32'(m_q.size() != 0 ? m_q[0] : 8'h00));
      check("bus_err", 32'(bus_err), 32'(m_berr));
      check("timer_irq", 32'(timer_irq), 32'(m_flag));
    end
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0; m_berr = 1'b0; m_flag = 1'b0;
      m_tcnt = 32'h0; m_tcmp = 32'hFFFF_FFFF;
      m_ok = 1'b1;
    end else if (m_ok) begin
      pop = (m_q.size() != 0) && rdy;
      if ((rd || wr) && kind == K_BAD) m_berr = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (wr) begin
        case (kind)
          K_RAM:  m_ram[idx] = wdata;
          K_CON:  if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]); else m_ovf = 1'b1;
          K_STAT: m_ovf = 1'b0;
          default: ;
        endcase
      end
`ifdef DMEM_TIMER_EN
      if (wr && kind == K_TCMP) m_flag = 1'b0;
      else if (m_tcnt == m_tcmp) m_flag = 1'b1;
      m_tcnt = (wr && kind == K_TCNT) ? wdata : m_tcnt + 32'd1;
      if (wr && kind == K_TCMP) m_tcmp = wdata;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_b;
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0;
    mem_addr = 32'h0; mem_writedata = 32'h0; con_ready = 1'b0;

    // reset state
    cycle(1, 0, 0, 32'h0, 32'h0, 0);
    cycle(1, 0, 0, 32'h0, 32'h0, 0);
    cycle(0, 1, 0, A_STAT, 32'h0, 0);
    check("rst_status", obs_rdata, 32'h0000_0002);
    check("rst_con_valid", 32'(obs_con_valid), 32'h0);
    check("rst_con_data", 32'(obs_con_data), 32'h0);
    check("rst_bus_err", 32'(obs_bus_err), 32'h0);
    check("rst_irq", 32'(obs_irq), 32'h0);

    // RAM write/read, neighbour untouched, read-during-write, top word
    cycle(0, 0, 1, 32'h14, 32'h1234_5678, 0);
    cycle(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    cycle(0, 1, 0, 32'h10, 32'h0, 0);
    check("ram_rd10", obs_rdata, 32'hDEAD_BEEF);
    cycle(0, 1, 0, 32'h14, 32'h0, 0);
    check("ram_rd14", obs_rdata, 32'h1234_5678);
    cycle(0, 1, 1, 32'h10, 32'hCAFE_F00D, 0);
    check("ram_rdw_old", obs_rdata, 32'hDEAD_BEEF);
    cycle(0, 1, 0, 32'h10, 32'h0, 0);
    check("ram_rdw_new", obs_rdata, 32'hCAFE_F00D);
    cycle(0, 0, 1, 32'(4 * WORDS - 4), 32'hA5A5_5A5A, 0);
    cycle(0, 1, 0, 32'(4 * WORDS - 4), 32'h0, 0);
    check("ram_top", obs_rdata, 32'hA5A5_5A5A);
    check("ram_top_no_err", 32'(obs_bus_err), 32'h0);

    // FIFO overflow: 9 pushes into depth 8 with sink stalled
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, A_CON, 32'(8'h41 + i), 0);
    cycle(0, 1, 0, A_STAT, 32'h0, 0);
    check("ovf_status", obs_rdata, 32'h0000_0809);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 32'h0, 32'h0, 1);
      check("drain_order", 32'(obs_con_data), 32'(8'h41 + i));
    end
    cycle(0, 1, 0, A_STAT, 32'h0, 1);
    check("drained_valid", 32'(obs_con_valid), 32'h0);
    check("drained_status", obs_rdata, 32'h0000_000A);
    cycle(0, 0, 1, A_STAT, 32'hFFFF_FFFF, 0);
    cycle(0, 1, 0, A_STAT, 32'h0, 0);
    check("ovf_cleared", obs_rdata, 32'h0000_0002);

    // full FIFO, push 'Z' together with a pop
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, A_CON, 32'(8'h61 + i), 0);
      if (i == 0) check("no_bypass", 32'(obs_con_valid), 32'h0);
    end
    cycle(0, 0, 1, A_CON, 32'h5A, 1);
    check("full_pop_head", 32'(obs_con_data), 32'h61);
    cycle(0, 1, 0, A_STAT, 32'h0, 0);
    check("full_push_status", obs_rdata, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(8'h62 + i) : 8'h5A;
      cycle(0, 0, 0, 32'h0, 32'h0, 1);
      check("z_drain", 32'(obs_con_data), 32'(exp_b));
    end
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    check("z_empty", 32'(obs_con_valid), 32'h0);

`ifdef DMEM_TIMER_EN
    // timer wrap and compare flag
    cycle(0, 0, 1, A_TCNT, 32'hFFFF_FFFE, 0);
    cycle(0, 0, 1, A_TCMP, 32'h0000_0001, 0);
    check("irq_c1", 32'(obs_irq), 32'h0);
    cycle(0, 1, 0, A_TCNT, 32'h0, 0);
    check("tcnt_max", obs_rdata, 32'hFFFF_FFFF);
    cycle(0, 1, 0, A_TCNT, 32'h0, 0);
    check("tcnt_wrap", obs_rdata, 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0, 0);
    check("irq_c4", 32'(obs_irq), 32'h0);
    cycle(0, 1, 0, A_STAT, 32'h0, 0);
    check("irq_rise", 32'(obs_irq), 32'h1);
    check("irq_status", obs_rdata, 32'h0000_0006);
    cycle(0, 0, 1, A_TCMP, 32'hFFFF_FFFF, 0);
    cycle(0, 0, 0, 32'h0, 32'h0, 0);
    check("irq_cleared", 32'(obs_irq), 32'h0);
`else
    cycle(0, 1, 0, A_TCNT, 32'h0, 0);
    check("tcnt_unmapped_rd", obs_rdata, 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0, 0);
    check("tcnt_unmapped_err", 32'(obs_bus_err), 32'h1);
    cycle(1, 0, 0, 32'h0, 32'h0, 0);
`endif

    // misaligned and unmapped reads
    cycle(1, 0, 0, 32'h0, 32'h0, 0);
    cycle(0, 1, 0, 32'h0000_0002, 32'h0, 0);
    check("misalign_rd", obs_rdata, 32'h0);
    check("berr_before", 32'(obs_bus_err), 32'h0);
    cycle(0, 1, 0, 32'hFFFF_0020, 32'h0, 0);
    check("unmapped_rd", obs_rdata, 32'h0);
    check("berr_set", 32'(obs_bus_err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 32'h0, 32'h0, 0);
      check("berr_sticky", 32'(obs_bus_err), 32'h1);
    end

    // reset mid-drain with 3 bytes queued
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, A_CON, 32'(8'h30 + i), 0);
    cycle(1, 0, 0, 32'h0, 32'h0, 1);
    cycle(0, 1, 0, A_STAT, 32'h0, 0);
    check("rst2_valid", 32'(obs_con_valid), 32'h0);
    check("rst2_status", obs_rdata, 32'h0000_0002);
    check("rst2_berr", 32'(obs_bus_err), 32'h0);
`ifdef DMEM_TIMER_EN
    cycle(0, 1, 0, A_TCNT, 32'h0, 0);
    check("rst2_tcnt", obs_rdata, 32'h1);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit          r_rst;
      bit          r_rd;
      bit          r_wr;
      bit          r_rdy;
      int          k;
      logic [31:0] a;
      r_rst = ($urandom_range(0, 99) < 3);
      k = $urandom_range(0, 19);
      if (k >= 15 && $urandom_range(0, 3) != 0) k = 0;
      if (k < 8)        a = 32'($urandom_range(0, 15)) * 32'd4;
      else if (k == 8)  a = 32'(4 * WORDS - 4);
      else if (k < 13)  a = A_CON;
      else if (k < 15)  a = A_STAT;
      else if (k == 15) a = A_TCNT;
      else if (k == 16) a = A_TCMP;
      else if (k == 17) a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (k == 18) a = 32'(4 * WORDS);
      else              a = 32'hFFFF_0000 + 32'($urandom_range(4, 64)) * 32'd4;
      r_rd  = r_rst ? 1'b0 : 1'($urandom_range(0, 1));
      r_wr  = r_rst ? 1'b0 : 1'($urandom_range(0, 1));
      r_rdy = ($urandom_range(0, 2) == 0);
      cycle(r_rst, r_rd, r_wr, a, $urandom, r_rdy);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
